// File: rtl/pcgen_pkg.sv
// pcgen_pkg: next-PC select encodings, FSM state type and alignment masks shared by pc_gen
package pcgen_pkg;
  localparam logic [1:0] PCSEL_FT4 = 2'b00;
  localparam logic [1:0] PCSEL_FT2 = 2'b10;
  localparam logic [1:0] PCSEL_TA  = 2'b01;
  localparam logic [1:0] PCSEL_IMM = 2'b11;
  typedef enum logic [1:0] {BOOT, RUN, TBUB} pcgen_state_e;
  localparam logic [63:0] ALIGN2_MASK = ~64'h1;
  localparam logic [63:0] ALIGN4_MASK = ~64'h3;
endpackage

// File: rtl/pcgen_ras.sv
// pcgen_ras: circular return-address stack; a full push overwrites the oldest entry
module pcgen_ras #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  assign top_idx = ptr_q - PW'(1);
  assign top_o   = mem_q[top_idx];
  assign empty_o = cnt_q == '0;
  // pointer tracks the next free slot; push+pop replaces the top in place
  always_comb begin
    ptr_d = push_i && !pop_i ? ptr_q + PW'(1) : pop_i && !push_i ? top_idx : ptr_q;
    cnt_d = push_i && !pop_i ? (cnt_q == CW'(DEPTH) ? cnt_q : cnt_q + CW'(1)) :
            pop_i && !push_i ? cnt_q - CW'(1) : cnt_q;
  end
  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  // entry storage, written at the free slot or over the popped top
  always_ff @(posedge clk) begin
    if (push_i) mem_q[pop_i ? top_idx : ptr_q] <= data_i;
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage PC unit with boot/trap-bubble FSM, EPC capture and MRET; RAS under `PCGEN_RAS_EN
module pc_gen
  import pcgen_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
`ifdef PCGEN_RAS_EN
  , parameter int unsigned   RAS_DEPTH = 4
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ta,
  input  logic [XLEN-1:0] imm,
  input  logic [1:0]      sel,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] ft_pc,
  output logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] epc
`ifdef PCGEN_RAS_EN
  , input  logic          ras_push
  , input  logic          ras_pop
  , output logic          ras_empty
`endif
);
  pcgen_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d, jmp;
  logic            step;
  assign fetch_valid = state_q == RUN;
  assign step        = fetch_valid && fetch_ready;
  assign pc          = pc_q;
  assign epc         = epc_q;
  assign ft_pc       = pc_q + (sel[1] ? XLEN'(2) : XLEN'(4));
  assign i_pc        = pc_q + imm;
`ifdef PCGEN_RAS_EN
  logic            adv, ras_hit;
  logic [XLEN-1:0] ras_top;
  assign adv     = step && !trap && !mret;
  assign ras_hit = adv && ras_pop && sel == PCSEL_TA && !ras_empty;
  assign jmp     = ras_hit ? ras_top : ta & XLEN'(ALIGN2_MASK);
  pcgen_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (adv && ras_push),
    .pop_i   (ras_hit),
    .data_i  (ft_pc),
    .top_o   (ras_top),
    .empty_o (ras_empty)
  );
`else
  assign jmp = ta & XLEN'(ALIGN2_MASK);
`endif
  // trap beats mret beats a fetch step; every non-trap cycle lands in RUN
  always_comb begin
    state_d = RUN;
    epc_d   = epc_q;
    pc_d    = pc_q;
    if (trap) begin
      state_d = TBUB;
      epc_d   = pc_q;
      pc_d    = trap_vec & XLEN'(ALIGN4_MASK);
    end else if (mret) begin
      pc_d = epc_q;
    end else if (step) begin
      pc_d = sel == PCSEL_TA ? jmp : sel == PCSEL_IMM ? i_pc : ft_pc;
    end
  end
  // state, PC and EPC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen (RAS steps only when PCGEN_RAS_EN is defined)
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst, fetch_ready, trap, mret, fetch_valid;
  logic [31:0] ta, imm, trap_vec, pc, ft_pc, i_pc, epc;
  logic [1:0]  sel;
  int          total = 0;
  int          bad = 0;
  logic [31:0] sb_exp[$];
  string       sb_tag[$];
`ifdef PCGEN_RAS_EN
  logic        ras_push, ras_pop, ras_empty;
  logic [31:0] ras_m[$];
`endif

  pc_gen #(.XLEN(32), .RESET_VEC(32'h1000)) dut (
    .clk         (clk),
    .rst         (rst),
    .ta          (ta),
    .imm         (imm),
    .sel         (sel),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .trap        (trap),
    .trap_vec    (trap_vec),
    .mret        (mret),
    .pc          (pc),
    .ft_pc       (ft_pc),
    .i_pc        (i_pc),
    .epc         (epc)
`ifdef PCGEN_RAS_EN
    , .ras_push  (ras_push)
    , .ras_pop   (ras_pop)
    , .ras_empty (ras_empty)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected PC is queued with the stimulus and retired when the edge has taken effect
  task automatic step(input string tag, input logic [31:0] exp);
    sb_exp.push_back(exp);
    sb_tag.push_back(tag);
    tick();
    chk(sb_tag.pop_front(), pc, sb_exp.pop_front());
  endtask

  initial begin
    rst = 1'b1; fetch_ready = 1'b0; trap = 1'b0; mret = 1'b0;
    ta = '0; imm = '0; trap_vec = '0; sel = 2'b00;
`ifdef PCGEN_RAS_EN
    ras_push = 1'b0; ras_pop = 1'b0;
`endif
    tick();
    step("reset_pc", 32'h1000);
    chk("reset_epc", epc, 32'h0);
    chk("boot_fv0", {31'b0, fetch_valid}, 32'd0);
    rst = 1'b0;
    step("boot_hold", 32'h1000);
    chk("run_fv1", {31'b0, fetch_valid}, 32'd1);
    fetch_ready = 1'b1;
    #1 chk("ft_pc4", ft_pc, 32'h1004);
    step("seq1", 32'h1004);
    step("seq2", 32'h1008);
    step("seq3", 32'h100C);
    fetch_ready = 1'b0;
    step("stall", 32'h100C);
    fetch_ready = 1'b1; sel = 2'b10;
    #1 chk("ft_pc2", ft_pc, 32'h100E);
    step("pc_plus2", 32'h100E);
    sel = 2'b01; ta = 32'h2003;
    step("ta_bit0", 32'h2002);
    ta = 32'h101;
    step("ta_0x100", 32'h100);
    sel = 2'b11; imm = 32'hFFFF_FFF0;
    #1 chk("i_pc", i_pc, 32'hF0);
    step("imm_neg", 32'hF0);
    sel = 2'b01; ta = 32'hFFFF_FFFD;
    step("ta_top", 32'hFFFF_FFFC);
    sel = 2'b00;
    step("wrap", 32'h0);
    sel = 2'b01; ta = 32'h1234;
    step("ta_1234", 32'h1234);
    sel = 2'b00; trap = 1'b1; trap_vec = 32'h8000_0101;
    step("trap_pc", 32'h8000_0100);
    chk("trap_epc", epc, 32'h1234);
    chk("trap_bubble", {31'b0, fetch_valid}, 32'd0);
    trap = 1'b0;
    step("bubble_hold", 32'h8000_0100);
    chk("after_bubble_fv", {31'b0, fetch_valid}, 32'd1);
    step("handler", 32'h8000_0104);
    mret = 1'b1;
    step("mret_pc", 32'h1234);
    chk("mret_fv", {31'b0, fetch_valid}, 32'd1);
    chk("mret_epc", epc, 32'h1234);
    mret = 1'b0;
    step("post_mret", 32'h1238);
    trap = 1'b1; mret = 1'b1; trap_vec = 32'h4000;
    step("trap_mret", 32'h4000);
    chk("trap_mret_epc", epc, 32'h1238);
    chk("trap_mret_fv", {31'b0, fetch_valid}, 32'd0);
    mret = 1'b0; trap_vec = 32'h7000; rst = 1'b1;
    step("rst_tbub_pc", 32'h1000);
    chk("rst_tbub_epc", epc, 32'h0);
    chk("rst_tbub_fv", {31'b0, fetch_valid}, 32'd0);
    rst = 1'b0; trap = 1'b0;
    step("reboot", 32'h1000);
    chk("reboot_fv", {31'b0, fetch_valid}, 32'd1);
`ifdef PCGEN_RAS_EN
    chk("ras_empty_rst", {31'b0, ras_empty}, 32'd1);
    sel = 2'b00; ras_push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ras_m.push_back(pc + 32'd4);
      if (ras_m.size() > 4) void'(ras_m.pop_front());
      step("ras_call", pc + 32'd4);
    end
    chk("ras_full_ne", {31'b0, ras_empty}, 32'd0);
    ras_push = 1'b0; ras_pop = 1'b1; sel = 2'b01; ta = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step("ras_ret", ras_m.size() != 0 ? ras_m.pop_back() : 32'h0);
      if (i == 3) chk("ras_empty_4th", {31'b0, ras_empty}, 32'd1);
    end
    ras_pop = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter unit for the RV32 core fetch stage.
- Generalises the PC-update datapath to XLEN bits and a configurable reset vector.
- Adds a fetch valid/ready handshake, a boot state, trap redirection with EPC capture, and MRET return.
- Optional return-address stack (RAS) for call/return prediction.

Parameters:
- XLEN, 32, PC/address width.
- RESET_VEC, 0, PC value loaded at reset.
- RAS_DEPTH, 4, RAS entries (power of 2, 2..16); used only with PCGEN_RAS_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ta  in  XLEN  jump target (JALR/ALU result).
- imm  in  XLEN  immediate from IMMGen.
- sel  in  2  next-PC select: 00 PC+4, 10 PC+2, 01 TA, 11 PC+Imm.
- fetch_valid  out  1  PC is valid for instruction fetch.
- fetch_ready  in  1  fetch consumer accepts PC this cycle.
- trap  in  1  take trap this cycle.
- trap_vec  in  XLEN  trap handler base (mtvec).
- mret  in  1  return from trap.
- pc  out  XLEN  current PC.
- ft_pc  out  XLEN  fall-through PC: PC+2 if sel[1], else PC+4.
- i_pc  out  XLEN  PC+imm.
- epc  out  XLEN  PC captured at last trap.
- ras_push  in  1  (PCGEN_RAS_EN only) current step is a call.
- ras_pop  in  1  (PCGEN_RAS_EN only) current step is a return.
- ras_empty  out  1  (PCGEN_RAS_EN only) RAS holds no entries.

Behaviour:
- Reset (sync, rst=1 at edge): pc=RESET_VEC, epc=0, fetch_valid=0, state=BOOT, RAS count=0. rst overrides every other input, including mid-trap or mid-handshake.
- FSM states:
  - BOOT: fetch_valid=0; next cycle -> RUN unconditionally.
  - RUN: fetch_valid=1.
  - TBUB: one-cycle bubble after trap; fetch_valid=0; -> RUN.
- step = fetch_valid & fetch_ready. The PC advances only on step; otherwise pc holds (stall).
- Next PC on step:
  - sel=00: pc+4.
  - sel=10: pc+2.
  - sel=01: {ta[XLEN-1:1],1'b0} (bit0 cleared).
  - sel=11: i_pc.
- Arithmetic is modulo 2^XLEN; wrap-around is legal and silent (0xFFFFFFFC+4 -> 0).
- Update latency: 1 cycle. ft_pc and i_pc are combinational from pc, sel and imm.
- Priority when events coincide: rst > trap > mret > step.
- trap (in any non-reset state, including BOOT and TBUB):
  - epc <= pc; pc <= {trap_vec[XLEN-1:2],2'b00}; state -> TBUB.
  - fetch_ready and sel are ignored that cycle.
- mret (no trap): pc <= epc; state -> RUN; no bubble; epc unchanged.
- trap and mret together: trap wins; mret dropped.
- fetch_valid is a registered state decode, never combinational from inputs.

Optional Feature:
- Macro: PCGEN_RAS_EN.
- With the macro defined:
  - Adds the RAS (RAS_DEPTH x XLEN circular buffer, pointer, count) and ports ras_push, ras_pop, ras_empty.
  - On step with ras_push=1: push ft_pc.
  - On step with ras_pop=1 and sel=01 and not empty: next PC = top entry instead of ta; pop.
  - Push and pop on the same step: pop supplies the next PC, then ft_pc is pushed; count unchanged.
  - Push when full: overwrite oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: use ta; count stays 0.
  - trap and mret leave the RAS untouched.
- Without the macro: no RAS ports or state; sel=01 always uses ta.

Decomposition:
- Shared package pcgen_pkg:
  - sel encodings PCSEL_FT4=2'b00, PCSEL_FT2=2'b10, PCSEL_TA=2'b01, PCSEL_IMM=2'b11.
  - FSM state typedef {BOOT, RUN, TBUB}.
  - ALIGN masks.
- One sub-module: pcgen_ras (the stack), instantiated only under PCGEN_RAS_EN.

Test Plan:
- Reset/boot: rst=1 for 2 cycles, RESET_VEC=0x1000 -> pc=0x1000, fetch_valid=0 in the first cycle after reset, fetch_valid=1 in the second.
- Sequential and stall:
  - sel=00, fetch_ready=1 x3 -> pc 0x1000, 0x1004, 0x1008, 0x100C.
  - fetch_ready=0 -> pc holds.
  - sel=10 -> pc+2.
- Redirect and wrap:
  - sel=01, ta=0x2003 -> pc=0x2002.
  - sel=11, pc=0x100, imm=0xFFFFFFF0 -> pc=0xF0.
  - pc=0xFFFFFFFC, sel=00 -> pc=0.
- Trap and return:
  - pc=0x1234, trap=1, trap_vec=0x8000_0101 with fetch_ready=1 -> epc=0x1234, pc=0x8000_0100, one cycle fetch_valid=0.
  - Later mret=1 -> pc=0x1234 with no bubble.
  - trap and mret in the same cycle -> trap taken.
- Reset mid-trap: assert rst during TBUB -> pc=RESET_VEC, epc=0, state BOOT.
- RAS (PCGEN_RAS_EN, RAS_DEPTH=4):
  - 5 pushes with ft_pc=A..E, then 5 pops with sel=01, ta=0x0 -> next PCs E, D, C, B, then ta=0x0.
  - ras_empty asserts after the 4th pop.
